// File: rtl/lklist_walker.sv
// Self-sequenced linked-list walker: follows next pointers through a synchronous
// read-only memory and sums node values. Optional running maximum: LKLIST_WALKER_MINMAX_EN.
module lklist_walker #(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int CW        = 16,
  parameter int MAX_NODES = 65535
) (
  input  logic          all_clk,
  input  logic          all_reset,
  input  logic          start,
  input  logic [AW-1:0] head_addr,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] the_sum,
  output logic [CW-1:0] node_count,
  output logic          sum_ovf,
  output logic          err_limit,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
`ifdef LKLIST_WALKER_MINMAX_EN
  output logic [DW-1:0] max_val,
`endif
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_PTR,
    FETCH_VAL,
    ACCUM,
    DONE
  } state_t;

  localparam logic [CW-1:0] LIMIT = CW'(MAX_NODES);

  state_t        state, state_nx;
  logic [AW-1:0] cur, nxt, addr_q;
  logic [CW-1:0] count_inc;
  logic [DW:0]   sum_ext;
  logic          limit_hit;

  assign count_inc = node_count + CW'(1);
  assign sum_ext   = {1'b0, the_sum} + {1'b0, mem_rdata};
  assign limit_hit = (nxt != '0) && (count_inc == LIMIT);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = addr_q;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (head_addr != '0) ? FETCH_PTR : DONE;
      end
      FETCH_PTR: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cur;
        state_nx = FETCH_VAL;
      end
      FETCH_VAL: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cur + AW'(1);
        state_nx = ACCUM;
      end
      ACCUM: begin
        busy     = 1'b1;
        state_nx = (nxt == '0 || limit_hit) ? DONE : FETCH_PTR;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge all_clk) begin
    if (all_reset) begin
      state      <= IDLE;
      cur        <= '0;
      nxt        <= '0;
      addr_q     <= '0;
      the_sum    <= '0;
      node_count <= '0;
      sum_ovf    <= 1'b0;
      err_limit  <= 1'b0;
`ifdef LKLIST_WALKER_MINMAX_EN
      max_val    <= '0;
`endif
    end else begin
      state <= state_nx;
      // mem_addr is held between reads by remembering the last issued address.
      if (mem_rd) addr_q <= mem_addr;
      unique case (state)
        IDLE: begin
          if (start) begin
            cur        <= head_addr;
            the_sum    <= '0;
            node_count <= '0;
            sum_ovf    <= 1'b0;
            err_limit  <= 1'b0;
`ifdef LKLIST_WALKER_MINMAX_EN
            max_val    <= '0;
`endif
          end
        end
        FETCH_VAL: nxt <= mem_rdata[AW-1:0];
        ACCUM: begin
          the_sum    <= sum_ext[DW-1:0];
          sum_ovf    <= sum_ovf | sum_ext[DW];
          node_count <= count_inc;
          cur        <= nxt;
          if (limit_hit) err_limit <= 1'b1;
`ifdef LKLIST_WALKER_MINMAX_EN
          if (mem_rdata > max_val) max_val <= mem_rdata;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lklist_walker.sv
// Scoreboard bench for lklist_walker: a list-walking reference model predicts each
// traversal result and its completion cycle; a monitor checks every done pulse.
module tb_lklist_walker;
  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int CW        = 16;
  localparam int MAX_NODES = 4;
  localparam int DEPTH     = 1 << AW;

  typedef struct {
    logic [DW-1:0] sum;
    logic [DW-1:0] maxv;
    int            count;
    bit            ovf;
    bit            err;
    int            t_done;
  } exp_t;

  logic          clk = 1'b0;
  logic          all_reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] head_addr = '0;
  logic          busy, done, sum_ovf, err_limit, mem_rd;
  logic [DW-1:0] the_sum;
  logic [CW-1:0] node_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
`ifdef LKLIST_WALKER_MINMAX_EN
  logic [DW-1:0] max_val;
`endif

  logic [DW-1:0] mem [DEPTH];
  exp_t          sb[$];
  int            cyc = 0;
  int            rd_cnt = 0;
  int            n_checks = 0;
  int            n_err = 0;
  int            last_t0 = 0;

  lklist_walker #(.DW(DW), .AW(AW), .CW(CW), .MAX_NODES(MAX_NODES)) dut (
    .all_clk   (clk),
    .all_reset (all_reset),
    .start     (start),
    .head_addr (head_addr),
    .busy      (busy),
    .done      (done),
    .the_sum   (the_sum),
    .node_count(node_count),
    .sum_ovf   (sum_ovf),
    .err_limit (err_limit),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
`ifdef LKLIST_WALKER_MINMAX_EN
    .max_val   (max_val),
`endif
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd === 1'b1) begin
      rd_cnt    <= rd_cnt + 1;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the list straight out of the memory array.
  function automatic exp_t model(input int head, input int t0);
    exp_t          e;
    int            cur, nxt;
    logic [DW:0]   acc;
    logic [DW-1:0] val;
    e = '{sum: '0, maxv: '0, count: 0, ovf: 1'b0, err: 1'b0, t_done: 0};
    cur = head;
    while (cur != 0) begin
      nxt = int'(mem[cur]) % DEPTH;
      val = mem[(cur + 1) % DEPTH];
      acc = {1'b0, e.sum} + {1'b0, val};
      if (acc[DW]) e.ovf = 1'b1;
      e.sum = acc[DW-1:0];
      if (val > e.maxv) e.maxv = val;
      e.count++;
      if (nxt == 0) break;
      if (e.count == MAX_NODES) begin
        e.err = 1'b1;
        break;
      end
      cur = nxt;
    end
    e.t_done = t0 + 3 * e.count + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (all_reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.t_done);
        check("busy_in_done", busy, 0);
        check("the_sum", the_sum, e.sum);
        check("node_count", node_count, e.count);
        check("sum_ovf", sum_ovf, e.ovf);
        check("err_limit", err_limit, e.err);
`ifdef LKLIST_WALKER_MINMAX_EN
        check("max_val", max_val, e.maxv);
`endif
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && done === 1'b0) break;
    end
    if (i == 100) check("idle_timeout", 1, 0);
  endtask

  task automatic start_walk(input int head, output int exp_count);
    exp_t e;
    wait_idle();
    e = model(head, cyc);
    last_t0 = cyc;
    exp_count = e.count;
    sb.push_back(e);
    start = 1'b1;
    head_addr = AW'(head);
    @(posedge clk);
    #1;
    start = 1'b0;
    head_addr = AW'($urandom);
  endtask

  task automatic wait_drained();
    int i;
    for (i = 0; i < 3 * MAX_NODES + 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  initial begin
    int n, rd0, k;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    all_reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", the_sum, 0);
    check("rst_count", node_count, 0);
    check("rst_ovf", sum_ovf, 0);
    check("rst_err", err_limit, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Three-node list 0x10 -> 0x20 -> 0x30, values 5, 7, 9.
    mem[8'h10] = 8'h20; mem[8'h11] = 8'd5;
    mem[8'h20] = 8'h30; mem[8'h21] = 8'd7;
    mem[8'h30] = 8'h00; mem[8'h31] = 8'd9;
    start_walk(8'h10, n);
    wait_drained();

    // Empty list: no memory reads at all.
    rd0 = rd_cnt;
    start_walk(0, n);
    wait_drained();
    @(posedge clk);
    #1;
    check("empty_no_reads", rd_cnt - rd0, 0);

    // 200 + 100 wraps to 44 in 8 bits.
    mem[8'h40] = 8'h50; mem[8'h41] = 8'd200;
    mem[8'h50] = 8'h00; mem[8'h51] = 8'd100;
    start_walk(8'h40, n);
    wait_drained();

    // Self-loop stopped by the node limit.
    mem[8'h04] = 8'h04; mem[8'h05] = 8'd3;
    start_walk(8'h04, n);
    wait_drained();

    // Node at the top address: its value lives at address 0.
    mem[8'hFF] = 8'h00; mem[8'h00] = 8'd33;
    start_walk(8'hFF, n);
    wait_drained();

    // Extra start during FETCH_VAL, then reset in the second ACCUM cycle.
    start_walk(8'h10, n);
    @(posedge clk);
    #1;
    start = 1'b1;
    head_addr = 8'h40;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < last_t0 + 6) @(posedge clk);
    #1;
    check("busy_before_reset", busy, 1);
    all_reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    all_reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", the_sum, 0);
    check("mid_rst_count", node_count, 0);
    check("mid_rst_mem_rd", mem_rd, 0);
    repeat (3) @(posedge clk);
    start_walk(8'h10, n);
    wait_drained();

    // Random memory images, random heads, stray starts while busy or in DONE.
    for (int t = 0; t < 40; t++) begin
      wait_idle();
      for (int i = 0; i < DEPTH; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      start_walk(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, DEPTH - 1)), n);
      k = $urandom_range(0, 3 * n);
      repeat (k) @(posedge clk);
      #1;
      start = 1'b1;
      head_addr = AW'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drained();
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
